// File: rtl/sram_test_master_if.sv
// Active-low asynchronous-SRAM style bus between the test master and the SRAM bridge slave port.
// The master drives strobes, address and write data; the slave returns read data.
interface sram_test_master_if #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 20
);
    logic                   m_chipselect_n;
    logic [DATA_BITS/8-1:0] m_byteenable_n;
    logic                   m_write_n;
    logic                   m_read_n;
    logic [ADDR_BITS-1:0]   m_address;
    logic [DATA_BITS-1:0]   m_writedata;
    logic [DATA_BITS-1:0]   m_readdata;

    modport master (
        output m_chipselect_n,
        output m_byteenable_n,
        output m_write_n,
        output m_read_n,
        output m_address,
        output m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_chipselect_n,
        input  m_byteenable_n,
        input  m_write_n,
        input  m_read_n,
        input  m_address,
        input  m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/sram_test_master.sv
// Fills or verifies a contiguous SRAM region with an incrementing pattern.
// Each word runs through SETUP / STROBE / HOLD; all bus outputs are registered.
module sram_test_master #(
    parameter int DATA_BITS     = 16,
    parameter int ADDR_BITS     = 20,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    input  logic [DATA_BITS-1:0] seed,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS:0]   err_count,
    output logic [ADDR_BITS-1:0] first_err_addr,
    output logic [DATA_BITS-1:0] first_err_data,
    sram_test_master_if.master   m
);

    localparam int CW      = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int BE_BITS = DATA_BITS / 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 mode_q;
    logic [DATA_BITS-1:0] pat_q;
    logic [ADDR_BITS:0]   rem_q;
    logic [CW-1:0]        cnt;
    logic                 last_strobe;
    logic                 active_nx;
    logic                 write_nx;
    logic                 read_nx;

    // Outputs are registered from the next state so each phase appears on the bus
    // in exactly the cycle the state machine is in that phase.
    always_comb begin
        state_nx    = state;
        last_strobe = (cnt == CNT_LAST);
        active_nx   = 1'b0;
        write_nx    = 1'b0;
        read_nx     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = (length == '0) ? DONE : SETUP;
            SETUP:   state_nx = STROBE;
            STROBE:  if (last_strobe) state_nx = HOLD;
            HOLD:    state_nx = (rem_q == (ADDR_BITS+1)'(1)) ? DONE : SETUP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        active_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        write_nx  = (state_nx == STROBE) && !mode_q;
        read_nx   = (state_nx == STROBE) && mode_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // rem_q counts words still to go; address and pattern advance only on HOLD->SETUP
    // so they stay stable for the whole access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q           <= 1'b0;
            pat_q            <= '0;
            rem_q            <= '0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            first_err_addr   <= '0;
            first_err_data   <= '0;
            m.m_chipselect_n <= 1'b1;
            m.m_byteenable_n <= '1;
            m.m_write_n      <= 1'b1;
            m.m_read_n       <= 1'b1;
            m.m_address      <= '0;
            m.m_writedata    <= '0;
        end else begin
            busy             <= active_nx;
            done             <= (state_nx == DONE);
            m.m_chipselect_n <= !active_nx;
            m.m_byteenable_n <= {BE_BITS{!active_nx}};
            m.m_write_n      <= !write_nx;
            m.m_read_n       <= !read_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q         <= mode;
                        pat_q          <= seed;
                        rem_q          <= length;
                        cnt            <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        if (length != '0) begin
                            m.m_address <= base_addr;
                            if (!mode) m.m_writedata <= seed;
                        end
                    end
                end
                SETUP: cnt <= '0;
                STROBE: begin
                    cnt <= cnt + CW'(1);
                    if (last_strobe && mode_q && (m.m_readdata != pat_q)) begin
                        err_count <= err_count + (ADDR_BITS+1)'(1);
                        if (err_count == '0) begin
                            first_err_addr <= m.m_address;
                            first_err_data <= m.m_readdata;
                        end
                    end
                end
                HOLD: begin
                    rem_q <= rem_q - (ADDR_BITS+1)'(1);
                    if (state_nx == SETUP) begin
                        m.m_address <= m.m_address + ADDR_BITS'(1);
                        pat_q       <= pat_q + DATA_BITS'(1);
                        if (!mode_q) m.m_writedata <= pat_q + DATA_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_test_master.sv
// Bench for sram_test_master: a sparse SRAM model on the bus, a cycle-indexed expectation
// model derived from command parameters, and directed fill/check/wrap/reset scenarios.
module tb_sram_test_master;

    localparam int DB = 16;
    localparam int AB = 20;
    localparam int S  = 2;
    localparam int W  = S + 2;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          mode;
    logic [AB-1:0] base_addr;
    logic [AB:0]   length;
    logic [DB-1:0] seed;
    logic          busy;
    logic          done;
    logic [AB:0]   err_count;
    logic [AB-1:0] first_err_addr;
    logic [DB-1:0] first_err_data;

    sram_test_master_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

    sram_test_master #(.DATA_BITS(DB), .ADDR_BITS(AB), .STROBE_CYCLES(S)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .mode          (mode),
        .base_addr     (base_addr),
        .length        (length),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .m             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DB-1:0] mem [logic [AB-1:0]];

    bit            track = 0;
    int            cyc;
    int            done_cyc;
    int            wcount;
    int            rcount;
    bit            exp_mode;
    logic [AB-1:0] exp_base;
    int            exp_len;
    logic [DB-1:0] exp_seed;
    int            exp_err;
    logic [AB-1:0] exp_fa;
    logic [DB-1:0] exp_fd;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [DB-1:0] mem_read(input logic [AB-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    // SRAM model: writes land while the write strobe is low; read data is presented
    // mid-cycle so it is stable at the edge that closes the strobe.
    always @(negedge clk) begin
        if (!bus.m_chipselect_n && !bus.m_write_n) mem[bus.m_address] = bus.m_writedata;
        bus.m_readdata = (!bus.m_chipselect_n && !bus.m_read_n) ? mem_read(bus.m_address) : '0;
    end

    // Expected bus behaviour of cycle c after the start edge follows from arithmetic alone:
    // word k = (c-1)/W, phase p = (c-1)%W, DONE at length*W+1.
    int            e_k, e_p, e_end;
    bit            e_act, e_strobe;
    logic [AB-1:0] e_addr;
    logic [DB-1:0] e_data;
    always @(negedge clk) begin
        if (track) begin
            e_end    = exp_len * W;
            e_act    = (cyc >= 1) && (cyc <= e_end);
            e_k      = e_act ? (cyc - 1) / W : 0;
            e_p      = e_act ? (cyc - 1) % W : 0;
            e_strobe = e_act && (e_p >= 1) && (e_p <= S);
            e_addr   = exp_base + AB'(e_k);
            e_data   = exp_seed + DB'(e_k);
            check_output($sformatf("busy@c%0d", cyc), 32'(busy), 32'(e_act));
            check_output($sformatf("done@c%0d", cyc), 32'(done), 32'(cyc == e_end + 1));
            check_output($sformatf("cs_n@c%0d", cyc), 32'(bus.m_chipselect_n), 32'(!e_act));
            check_output($sformatf("be_n@c%0d", cyc), 32'(bus.m_byteenable_n), e_act ? 32'h0 : 32'h3);
            check_output($sformatf("write_n@c%0d", cyc), 32'(bus.m_write_n), 32'(!(e_strobe && !exp_mode)));
            check_output($sformatf("read_n@c%0d", cyc), 32'(bus.m_read_n), 32'(!(e_strobe && exp_mode)));
            if (e_act) check_output($sformatf("addr@c%0d", cyc), 32'(bus.m_address), 32'(e_addr));
            if (e_act && !exp_mode) check_output($sformatf("wdata@c%0d", cyc), 32'(bus.m_writedata), 32'(e_data));
            if (cyc == e_end + 1) begin
                check_output("err_count", 32'(err_count), 32'(exp_err));
                check_output("first_err_addr", 32'(first_err_addr), 32'(exp_fa));
                check_output("first_err_data", 32'(first_err_data), 32'(exp_fd));
            end
            if (done) done_cyc = cyc;
            if (!bus.m_write_n) wcount++;
            if (!bus.m_read_n) rcount++;
            if (cyc == e_end + 2) track = 0;
            cyc++;
        end
    end

    task automatic apply_stimulus(input bit md, input logic [AB-1:0] b, input int len,
                                  input logic [DB-1:0] sd, input int glitch);
        int budget;
        exp_mode = md;
        exp_base = b;
        exp_len  = len;
        exp_seed = sd;
        exp_err  = 0;
        exp_fa   = '0;
        exp_fd   = '0;
        if (md) begin
            for (int k = 0; k < len; k++) begin
                if (mem_read(b + AB'(k)) != sd + DB'(k)) begin
                    if (exp_err == 0) begin
                        exp_fa = b + AB'(k);
                        exp_fd = mem_read(b + AB'(k));
                    end
                    exp_err++;
                end
            end
        end
        @(posedge clk); #2;
        mode      = md;
        base_addr = b;
        length    = (AB+1)'(len);
        seed      = sd;
        start     = 1'b1;
        cyc       = 0;
        done_cyc  = -1;
        wcount    = 0;
        rcount    = 0;
        track     = 1;
        budget    = len * W + 10;
        for (int c = 1; c <= budget && track; c++) begin
            @(posedge clk); #2;
            start = (c == glitch);
            if (c == glitch) begin
                mode      = ~md;
                base_addr = '0;
                length    = 21'd9;
                seed      = '0;
            end
        end
        start = 1'b0;
        check_output("cmd_finished", 32'(track), 32'h0);
        track = 0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        length    = '0;
        seed      = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_output("rst_cs_n", 32'(bus.m_chipselect_n), 32'h1);
        check_output("rst_write_n", 32'(bus.m_write_n), 32'h1);
        check_output("rst_read_n", 32'(bus.m_read_n), 32'h1);
        check_output("rst_be_n", 32'(bus.m_byteenable_n), 32'h3);
        check_output("rst_addr", 32'(bus.m_address), 32'h0);
        check_output("rst_wdata", 32'(bus.m_writedata), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_err_count", 32'(err_count), 32'h0);
        check_output("rst_first_err_addr", 32'(first_err_addr), 32'h0);
        check_output("rst_first_err_data", 32'(first_err_data), 32'h0);

        apply_stimulus(1'b0, 20'h00010, 4, 16'h1234, 0);
        check_output("fill_done_cycle", 32'(done_cyc), 32'd17);
        check_output("fill_write_cycles", 32'(wcount), 32'd8);
        check_output("fill_mem10", 32'(mem_read(20'h00010)), 32'h1234);
        check_output("fill_mem11", 32'(mem_read(20'h00011)), 32'h1235);
        check_output("fill_mem12", 32'(mem_read(20'h00012)), 32'h1236);
        check_output("fill_mem13", 32'(mem_read(20'h00013)), 32'h1237);

        apply_stimulus(1'b1, 20'h00010, 4, 16'h1234, 0);
        check_output("check_done_cycle", 32'(done_cyc), 32'd17);
        check_output("check_read_cycles", 32'(rcount), 32'd8);
        check_output("check_clean_err", 32'(err_count), 32'h0);

        mem[20'h00012] = 16'hBEEF;
        apply_stimulus(1'b1, 20'h00010, 4, 16'h1234, 0);
        check_output("corrupt_err_count", 32'(err_count), 32'h1);
        check_output("corrupt_first_addr", 32'(first_err_addr), 32'h00012);
        check_output("corrupt_first_data", 32'(first_err_data), 32'hBEEF);

        apply_stimulus(1'b0, 20'hFFFFE, 4, 16'hFFFF, 0);
        check_output("wrap_memFFFFE", 32'(mem_read(20'hFFFFE)), 32'hFFFF);
        check_output("wrap_memFFFFF", 32'(mem_read(20'hFFFFF)), 32'h0000);
        check_output("wrap_mem00000", 32'(mem_read(20'h00000)), 32'h0001);
        check_output("wrap_mem00001", 32'(mem_read(20'h00001)), 32'h0002);

        apply_stimulus(1'b0, 20'h00100, 0, 16'h7777, 0);
        check_output("len0_done_cycle", 32'(done_cyc), 32'd1);
        check_output("len0_no_write", 32'(wcount), 32'd0);

        apply_stimulus(1'b0, 20'h00200, 3, 16'hA000, 5);
        check_output("glitch_mem202", 32'(mem_read(20'h00202)), 32'hA002);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_output($sformatf("glitch_idle_cs_n%0d", c), 32'(bus.m_chipselect_n), 32'h1);
        end

        @(posedge clk); #2;
        mode      = 1'b0;
        base_addr = 20'h00040;
        length    = 21'd3;
        seed      = 16'h0055;
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        check_output("pre_reset_write_n", 32'(bus.m_write_n), 32'h0);
        reset_n = 1'b0;
        #1;
        check_output("async_write_n", 32'(bus.m_write_n), 32'h1);
        check_output("async_cs_n", 32'(bus.m_chipselect_n), 32'h1);
        check_output("async_busy", 32'(busy), 32'h0);
        check_output("async_done", 32'(done), 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check_output($sformatf("post_reset_done%0d", c), 32'(done), 32'h0);
            check_output($sformatf("post_reset_cs_n%0d", c), 32'(bus.m_chipselect_n), 32'h1);
        end

        apply_stimulus(1'b0, 20'h00040, 3, 16'h0055, 0);
        check_output("after_reset_done_cycle", 32'(done_cyc), 32'd13);
        check_output("after_reset_mem42", 32'(mem_read(20'h00042)), 32'h0057);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
